// File: rtl/ssp_iq_deframer.sv
// Receive side of the FPGA->ARM SSP link. Oversamples the SSP pins, rebuilds
// 16-bit I/Q reports and queues them in a first-word-fall-through FIFO.
module ssp_iq_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       ssp_clk,
  input  logic       ssp_frame,
  input  logic       ssp_din,
  input  logic       snoop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_i,
  output logic [7:0] out_q,
  output logic [1:0] out_rdr,
  output logic       overflow,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   PTR_ONE = 1;

  typedef enum logic [1:0] {HUNT, BYTE_I, BYTE_Q} state_t;

  // ---------------- input synchronisers and fall detect ----------------
  logic [SYNC_STAGES-1:0] clk_sync, frame_sync, din_sync;
  logic                   clk_prev;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      clk_sync   <= '0;
      frame_sync <= '0;
      din_sync   <= '0;
      clk_prev   <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ssp_clk};
      frame_sync <= {frame_sync[SYNC_STAGES-2:0], ssp_frame};
      din_sync   <= {din_sync[SYNC_STAGES-2:0], ssp_din};
      clk_prev   <= clk_sync[SYNC_STAGES-1];
    end
  end

  logic e, frame_s, din_s;
  assign e       = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign frame_s = frame_sync[SYNC_STAGES-1];
  assign din_s   = din_sync[SYNC_STAGES-1];

  // ---------------- deframer FSM ----------------
  state_t        state, state_d;
  logic [2:0]    cnt, cnt_d;
  logic [15:0]   sh, sh_d;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, err_evt, rpt_done;
  logic [15:0]   rpt_word;

  assign tmo_hit  = !e && (tmo_cnt == TMO_MAX);
  assign rpt_word = {sh[14:0], din_s};

  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= 3'd0;
      sh        <= '0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sh        <= sh_d;
      frame_err <= err_evt;
      if (e)                   tmo_cnt <= '0;
      else if (!tmo_hit)       tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    if (e) begin
      if (state == HUNT) begin
        if (frame_s) begin
          sh_d    = {15'd0, din_s};
          state_d = BYTE_I;
          cnt_d   = 3'd1;
        end
      end else if (frame_s && cnt != 3'd0) begin
        // Frame mid-byte: treat this bit as the start of a fresh report.
        sh_d    = {15'd0, din_s};
        state_d = BYTE_I;
        cnt_d   = 3'd1;
      end else if (!frame_s && cnt == 3'd0) begin
        state_d = HUNT;
        cnt_d   = 3'd0;
      end else begin
        sh_d  = rpt_word;
        cnt_d = cnt + 3'd1;
        if (cnt == 3'd7) state_d = (state == BYTE_I) ? BYTE_Q : BYTE_I;
      end
    end else if (tmo_hit && state != HUNT) begin
      state_d = HUNT;
      cnt_d   = 3'd0;
    end
  end

  always_comb begin
    err_evt  = 1'b0;
    rpt_done = 1'b0;
    if (e) begin
      err_evt  = (state != HUNT) && (frame_s != (cnt == 3'd0));
      rpt_done = (state == BYTE_Q) && (cnt == 3'd7) && !frame_s;
    end else if (tmo_hit) begin
      // Idle at a report boundary is legal and falls back to HUNT silently.
      err_evt = (state == BYTE_Q) || (state == BYTE_I && cnt != 3'd0);
    end
  end

  // ---------------- report FIFO ----------------
  logic [16:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;
  logic [17:0] head_map, last_map;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = rpt_done && (!full || pop);

  function automatic logic [17:0] map_entry(input logic [16:0] ent);
    if (ent[16]) return {ent[15], ent[15:9], ent[7], ent[7:1], ent[8], ent[0]};
    else         return {ent[15:0], 2'b00};
  endfunction

  assign head_map = map_entry(mem[rd_ptr[AW-1:0]]);

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and outputs never expose an unwritten slot.
  always_ff @(posedge ck_1356meg) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {snoop, rpt_word};
  end

  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_map <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        last_map <= head_map;
      end
      if (rpt_done && !push) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
    end
  end

  assign out_valid = !empty;
  assign {out_i, out_q, out_rdr} = empty ? last_map : head_map;

endmodule
